// File: rtl/hba_arbiter.sv
// hba_arbiter: four-master round-robin bus arbiter with hold-limit revocation.
// A grant lasts until the master lets go (request and select both low) or,
// once it has held the bus HOLD_LIMIT cycles, until the next transfer
// acknowledge while another master is waiting. Every handover passes through
// one RELEASE cycle and one IDLE cycle with the bus parked at zero.
module hba_arbiter #(
    parameter int DBUS_WIDTH = 8,
    parameter int ADDR_WIDTH = 12,
    parameter int HOLD_LIMIT = 16
) (
    input  logic                    hba_clk,
    input  logic                    hba_reset,
    input  logic [3:0]              master_request,
    input  logic [3:0]              master_rnw,
    input  logic [3:0]              master_select,
    input  logic [4*ADDR_WIDTH-1:0] master_abus,
    input  logic [4*DBUS_WIDTH-1:0] master_dbus,
    input  logic                    hba_xferack,
    output logic [3:0]              master_grant,
    output logic [3:0]              master_xferack,
    output logic                    hba_rnw,
    output logic                    hba_select,
    output logic [ADDR_WIDTH-1:0]   hba_abus,
    output logic [DBUS_WIDTH-1:0]   hba_dbus
);

    localparam int HW = $clog2(HOLD_LIMIT + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_LIMIT);

    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

    state_t          state, state_nxt;
    logic [3:0]      grant_nxt;
    logic [1:0]      gidx, gidx_nxt;
    logic [1:0]      last_grant, last_nxt;
    logic [HW-1:0]   hold_cnt, hold_nxt;
    logic [1:0]      winner, cand;
    logic            found;
    logic            others;
    logic            release_vol, release_force;

    // Round-robin search starting one past the last released master, with wrap.
    always_comb begin
        winner = last_grant + 2'd1;
        cand   = '0;
        found  = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            cand = last_grant + 2'(i);
            if (!found && master_request[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    // Release conditions; the forced one needs an ack so an in-flight
    // transfer is never cut short.
    always_comb begin
        others        = |(master_request & ~master_grant);
        release_vol   = !master_request[gidx] && !master_select[gidx];
        release_force = hba_xferack && (hold_cnt >= HOLD_MAX) && others;
    end

    // Next-state and next-register logic for the arbitration FSM.
    always_comb begin
        state_nxt = state;
        grant_nxt = master_grant;
        gidx_nxt  = gidx;
        last_nxt  = last_grant;
        hold_nxt  = hold_cnt;
        case (state)
            IDLE: begin
                grant_nxt = 4'b0000;
                if (found) begin
                    grant_nxt = 4'b0001 << winner;
                    gidx_nxt  = winner;
                    hold_nxt  = '0;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (hold_cnt < HOLD_MAX) hold_nxt = hold_cnt + HW'(1);
                if (release_vol || release_force) begin
                    grant_nxt = 4'b0000;
                    last_nxt  = gidx;
                    state_nxt = RELEASE;
                end
            end
            RELEASE: begin
                grant_nxt = 4'b0000;
                state_nxt = IDLE;
            end
            default: begin
                grant_nxt = 4'b0000;
                state_nxt = IDLE;
            end
        endcase
    end

    // State and grant registers; reset parks the pointer so master 0 wins first.
    always_ff @(posedge hba_clk) begin
        if (hba_reset) begin
            state        <= IDLE;
            master_grant <= 4'b0000;
            gidx         <= 2'd0;
            last_grant   <= 2'd3;
            hold_cnt     <= '0;
        end else begin
            state        <= state_nxt;
            master_grant <= grant_nxt;
            gidx         <= gidx_nxt;
            last_grant   <= last_nxt;
            hold_cnt     <= hold_nxt;
        end
    end

    // Bus mux follows the granted master; parked at zero with no grant.
    always_comb begin
        hba_rnw    = 1'b0;
        hba_select = 1'b0;
        hba_abus   = '0;
        hba_dbus   = '0;
        if (state == GRANT) begin
            hba_rnw    = master_rnw[gidx];
            hba_select = master_select[gidx];
            hba_abus   = master_abus[gidx*ADDR_WIDTH +: ADDR_WIDTH];
            hba_dbus   = master_dbus[gidx*DBUS_WIDTH +: DBUS_WIDTH];
        end
    end

    // Acks only reach the granted master; stray acks with no grant vanish.
    always_comb begin
        master_xferack = {4{hba_xferack}} & master_grant;
    end

endmodule

// File: tb/tb_hba_arbiter.sv
// Directed bench for hba_arbiter: reset, stray ack, single requester,
// mid-transfer drop, lone master under acks, round robin, reset mid-transfer.
module tb_hba_arbiter;

    localparam int DW = 8;
    localparam int AW = 12;

    logic          hba_clk = 1'b0;
    logic          hba_reset;
    logic [3:0]    master_request, master_rnw, master_select;
    logic [4*AW-1:0] master_abus;
    logic [4*DW-1:0] master_dbus;
    logic          hba_xferack;
    logic [3:0]    master_grant, master_xferack;
    logic          hba_rnw, hba_select;
    logic [AW-1:0] hba_abus;
    logic [DW-1:0] hba_dbus;

    int checks = 0;
    int errors = 0;

    logic [AW-1:0] addr_tab [4];
    logic [DW-1:0] data_tab [4];

    hba_arbiter #(.DBUS_WIDTH(DW), .ADDR_WIDTH(AW), .HOLD_LIMIT(16)) dut (
        .hba_clk(hba_clk), .hba_reset(hba_reset),
        .master_request(master_request), .master_rnw(master_rnw),
        .master_select(master_select), .master_abus(master_abus),
        .master_dbus(master_dbus), .hba_xferack(hba_xferack),
        .master_grant(master_grant), .master_xferack(master_xferack),
        .hba_rnw(hba_rnw), .hba_select(hba_select),
        .hba_abus(hba_abus), .hba_dbus(hba_dbus)
    );

    always #5 hba_clk = ~hba_clk;

    task automatic tick();
        @(posedge hba_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        addr_tab = '{12'h011, 12'h122, 12'h233, 12'h344};
        data_tab = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};
        master_abus = {addr_tab[3], addr_tab[2], addr_tab[1], addr_tab[0]};
        master_dbus = {data_tab[3], data_tab[2], data_tab[1], data_tab[0]};
        master_rnw     = 4'b1010;
        master_request = 4'b0000;
        master_select  = 4'b0000;
        hba_xferack    = 1'b0;
        hba_reset      = 1'b1;

        // Reset state
        tick(); tick();
        chk("rst_grant", 32'(master_grant), 32'h0);
        chk("rst_select", 32'(hba_select), 32'h0);
        chk("rst_abus", 32'(hba_abus), 32'h0);
        chk("rst_dbus", 32'(hba_dbus), 32'h0);
        hba_reset = 1'b0;

        // Stray ack while idle
        hba_xferack = 1'b1;
        tick();
        chk("stray_xack", 32'(master_xferack), 32'h0);
        chk("stray_grant", 32'(master_grant), 32'h0);
        hba_xferack = 1'b0;

        // Single requester, master 0
        master_request = 4'b0001;
        master_select  = 4'b0001;
        tick();
        chk("m0_grant", 32'(master_grant), 32'h1);
        chk("m0_abus", 32'(hba_abus), 32'h011);
        chk("m0_dbus", 32'(hba_dbus), 32'hA0);
        chk("m0_rnw", 32'(hba_rnw), 32'h0);
        chk("m0_select", 32'(hba_select), 32'h1);
        hba_xferack = 1'b1;
        tick();
        chk("m0_xack", 32'(master_xferack), 32'h1);
        hba_xferack    = 1'b0;
        master_request = 4'b0000;
        master_select  = 4'b0000;
        tick();
        chk("m0_release_grant", 32'(master_grant), 32'h0);
        chk("m0_release_sel", 32'(hba_select), 32'h0);
        tick();
        chk("m0_idle_grant", 32'(master_grant), 32'h0);

        // Mid-transfer drop, master 1
        master_request = 4'b0010;
        master_select  = 4'b0010;
        tick();
        chk("m1_grant", 32'(master_grant), 32'h2);
        chk("m1_rnw", 32'(hba_rnw), 32'h1);
        chk("m1_abus", 32'(hba_abus), 32'h122);
        master_request = 4'b0000;
        tick();
        chk("m1_hold_a", 32'(master_grant), 32'h2);
        tick();
        chk("m1_hold_b", 32'(master_grant), 32'h2);
        hba_xferack = 1'b1;
        tick();
        chk("m1_xack", 32'(master_xferack), 32'h2);
        chk("m1_hold_ack", 32'(master_grant), 32'h2);
        hba_xferack   = 1'b0;
        master_select = 4'b0000;
        tick();
        chk("m1_release", 32'(master_grant), 32'h0);
        tick();
        chk("m1_idle", 32'(master_grant), 32'h0);

        // Master 2 alone with acks every cycle: no forced release
        master_request = 4'b0100;
        master_select  = 4'b0100;
        hba_xferack    = 1'b1;
        for (int k = 0; k < 100; k++) begin
            tick();
            chk("m2_alone", 32'(master_grant), 32'h4);
        end
        master_request = 4'b0000;
        master_select  = 4'b0000;
        hba_xferack    = 1'b0;
        tick();
        chk("m2_release", 32'(master_grant), 32'h0);
        tick();

        // Round robin under full load after a reset
        hba_reset = 1'b1;
        tick();
        hba_reset      = 1'b0;
        master_request = 4'b1111;
        master_select  = 4'b1111;
        hba_xferack    = 1'b1;
        tick();
        for (int n = 0; n < 5; n++) begin
            automatic int m = n % 4;
            chk("rr_abus", 32'(hba_abus), 32'(addr_tab[m]));
            chk("rr_dbus", 32'(hba_dbus), 32'(data_tab[m]));
            for (int k = 1; k <= 17; k++) begin
                chk("rr_grant", 32'(master_grant), 32'(4'b0001 << m));
                chk("rr_xack", 32'(master_xferack), 32'(4'b0001 << m));
                tick();
            end
            chk("rr_dead1", 32'(master_grant), 32'h0);
            chk("rr_dead1_sel", 32'(hba_select), 32'h0);
            tick();
            chk("rr_dead2", 32'(master_grant), 32'h0);
            tick();
        end
        chk("rr_next", 32'(master_grant), 32'h2);

        // Reset mid-transfer with master 3 granted
        hba_xferack    = 1'b0;
        master_request = 4'b1000;
        master_select  = 4'b1000;
        tick();
        chk("m3_pre_release", 32'(master_grant), 32'h0);
        tick();
        tick();
        chk("m3_grant", 32'(master_grant), 32'h8);
        chk("m3_select", 32'(hba_select), 32'h1);
        chk("m3_abus", 32'(hba_abus), 32'h344);
        hba_reset = 1'b1;
        tick();
        chk("m3_rst_grant", 32'(master_grant), 32'h0);
        chk("m3_rst_select", 32'(hba_select), 32'h0);
        hba_reset      = 1'b0;
        master_request = 4'b1111;
        master_select  = 4'b1111;
        tick();
        chk("post_rst_grant", 32'(master_grant), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
